// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, register layouts
// and the software-writable masks.
package cp0_regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned EXC_CODE_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_BADVADDR = 5'd8;
  localparam logic [REG_ADDR_W-1:0] REG_COUNT    = 5'd9;
  localparam logic [REG_ADDR_W-1:0] REG_COMPARE  = 5'd11;
  localparam logic [REG_ADDR_W-1:0] REG_STATUS   = 5'd12;
  localparam logic [REG_ADDR_W-1:0] REG_CAUSE    = 5'd13;
  localparam logic [REG_ADDR_W-1:0] REG_EPC      = 5'd14;

  localparam logic [EXC_CODE_W-1:0] CODE_INT  = 5'd0;
  localparam logic [EXC_CODE_W-1:0] CODE_ADEL = 5'd4;
  localparam logic [EXC_CODE_W-1:0] CODE_ADES = 5'd5;
  localparam logic [EXC_CODE_W-1:0] CODE_SYS  = 5'd8;
  localparam logic [EXC_CODE_W-1:0] CODE_BP   = 5'd9;
  localparam logic [EXC_CODE_W-1:0] CODE_RI   = 5'd10;
  localparam logic [EXC_CODE_W-1:0] CODE_OV   = 5'd12;

  localparam logic [DATA_W-1:0] STATUS_WMASK = 32'h0000_FF03;

  typedef struct packed {
    logic [8:0] rsvd_hi;
    logic       bev;
    logic [5:0] rsvd_mid;
    logic [7:0] im;
    logic [5:0] rsvd_lo;
    logic       exl;
    logic       ie;
  } cp0_status_t;

  typedef struct packed {
    logic                  bd;
    logic                  ti;
    logic [13:0]           rsvd_hi;
    logic [7:0]            ip;
    logic                  rsvd_mid;
    logic [EXC_CODE_W-1:0] exc_code;
    logic [1:0]            rsvd_lo;
  } cp0_cause_t;

  typedef struct packed {
    cp0_status_t       status;
    cp0_cause_t        cause;
    logic [DATA_W-1:0] epc;
    logic [DATA_W-1:0] badvaddr;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] compare;
  } cp0_regs_t;

  function automatic logic is_addr_err(input logic [EXC_CODE_W-1:0] code);
    return (code == CODE_ADEL) || (code == CODE_ADES);
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: prescaled Count, Compare match latch (TI).
module cp0_timer
  import cp0_regfile_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              count_we,
  input  logic              compare_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] compare,
  output logic              timer_int
);

  localparam int unsigned PHASE_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [PHASE_W-1:0] phase_q;
  logic               count_chg_q;
  logic               wrap;

  assign wrap = (phase_q == PHASE_W'(COUNT_DIV - 1));

  // TI latches one cycle after Count takes a new value equal to Compare
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= '0;
      count       <= '0;
      compare     <= '0;
      timer_int   <= 1'b0;
      count_chg_q <= 1'b0;
    end else begin
      if (count_we) begin
        count   <= wdata;
        phase_q <= '0;
      end else begin
        phase_q <= wrap ? '0 : phase_q + PHASE_W'(1);
        if (wrap) count <= count + DATA_W'(1);
      end
      count_chg_q <= count_we | wrap;
      if (compare_we) begin
        compare   <= wdata;
        timer_int <= 1'b0;
      end else if (count_chg_q && (count == compare)) begin
        timer_int <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: exception commit, ERET, MTC0/MFC0 and interrupt vector.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int unsigned       COUNT_DIV    = 2,
  parameter logic [DATA_W-1:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            ext_int,
  input  logic                  exc_valid,
  input  logic [EXC_CODE_W-1:0] exc_code,
  input  logic [DATA_W-1:0]     exc_pc,
  input  logic                  exc_in_delay_slot,
  input  logic [DATA_W-1:0]     exc_badvaddr,
  input  logic                  eret,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0]     rdata,
  output logic [DATA_W-1:0]     epc,
  output cp0_regs_t             cp0_data,
  output logic [7:0]            interrupt_info
);

  cp0_status_t           status_q;
  logic [DATA_W-1:0]     epc_q;
  logic [DATA_W-1:0]     badvaddr_q;
  logic                  bd_q;
  logic [EXC_CODE_W-1:0] exc_code_q;
  logic [1:0]            ip_sw_q;
  logic [5:0]            ext_q;
  logic [DATA_W-1:0]     count;
  logic [DATA_W-1:0]     compare;
  logic                  timer_int;
  logic                  mtc0_ok;
  cp0_cause_t            cause_c;

  // MTC0 only lands when no exception or ERET commits in the same cycle
  assign mtc0_ok = we && !exc_valid && !eret;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (mtc0_ok && (waddr == REG_COUNT)),
    .compare_we (mtc0_ok && (waddr == REG_COMPARE)),
    .wdata      (wdata),
    .count      (count),
    .compare    (compare),
    .timer_int  (timer_int)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q   <= cp0_status_t'(RESET_STATUS);
      epc_q      <= '0;
      badvaddr_q <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      ip_sw_q    <= '0;
      ext_q      <= '0;
    end else begin
      ext_q <= ext_int;
      if (exc_valid) begin
        if (!status_q.exl) begin
          epc_q <= exc_in_delay_slot ? exc_pc - DATA_W'(4) : exc_pc;
          bd_q  <= exc_in_delay_slot;
        end
        status_q.exl <= 1'b1;
        exc_code_q   <= exc_code;
        if (is_addr_err(exc_code)) badvaddr_q <= exc_badvaddr;
      end else if (eret) begin
        status_q.exl <= 1'b0;
      end else if (we) begin
        case (waddr)
          REG_STATUS: status_q <= cp0_status_t'((DATA_W'(status_q) & ~STATUS_WMASK)
                                                | (wdata & STATUS_WMASK));
          REG_CAUSE:  ip_sw_q  <= wdata[9:8];
          REG_EPC:    epc_q    <= wdata;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    cause_c          = '0;
    cause_c.bd       = bd_q;
    cause_c.ti       = timer_int;
    cause_c.ip       = {ext_q[5] | timer_int, ext_q[4:0], ip_sw_q};
    cause_c.exc_code = exc_code_q;
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr_q;
      REG_COUNT:    rdata = count;
      REG_COMPARE:  rdata = compare;
      REG_STATUS:   rdata = DATA_W'(status_q);
      REG_CAUSE:    rdata = DATA_W'(cause_c);
      REG_EPC:      rdata = epc_q;
      default:      rdata = '0;
    endcase
  end

  assign epc            = epc_q;
  assign interrupt_info = cause_c.ip & status_q.im;

  always_comb begin
    cp0_data          = '0;
    cp0_data.status   = status_q;
    cp0_data.cause    = cause_c;
    cp0_data.epc      = epc_q;
    cp0_data.badvaddr = badvaddr_q;
    cp0_data.count    = count;
    cp0_data.compare  = compare;
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile.
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  logic        clk;
  logic        reset;
  logic [5:0]  ext_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_delay_slot;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [31:0] epc;
  cp0_regs_t   cp0_data;
  logic [7:0]  interrupt_info;

  int checks = 0;
  int errors = 0;

  cp0_regfile #(.COUNT_DIV(2), .RESET_STATUS(32'h0040_0000)) dut (
    .clk               (clk),
    .reset             (reset),
    .ext_int           (ext_int),
    .exc_valid         (exc_valid),
    .exc_code          (exc_code),
    .exc_pc            (exc_pc),
    .exc_in_delay_slot (exc_in_delay_slot),
    .exc_badvaddr      (exc_badvaddr),
    .eret              (eret),
    .we                (we),
    .waddr             (waddr),
    .wdata             (wdata),
    .raddr             (raddr),
    .rdata             (rdata),
    .epc               (epc),
    .cp0_data          (cp0_data),
    .interrupt_info    (interrupt_info)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    raddr = a;
    #1;
    v = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    rd(5'd12, v); checks++;
    if (v !== 32'h0040_0000) begin errors++; $display("FAIL reset_status: got %h expected %h", v, 32'h0040_0000); end
    rd(5'd13, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_cause: got %h expected %h", v, 32'h0); end
    rd(5'd14, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_epc_reg: got %h expected %h", v, 32'h0); end
    rd(5'd20, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_unmapped: got %h expected %h", v, 32'h0); end
    checks++;
    if (interrupt_info !== 8'h00) begin errors++; $display("FAIL reset_intinfo: got %h expected %h", interrupt_info, 8'h00); end
    checks++;
    if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc_out: got %h expected %h", epc, 32'h0); end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    exc_valid = 1'b1; exc_code = 5'd4; exc_pc = 32'hBFC0_0100;
    exc_in_delay_slot = 1'b1; exc_badvaddr = 32'h1234_5671;
    step();
    exc_valid = 1'b0;
    checks++;
    if (epc !== 32'hBFC0_00FC) begin errors++; $display("FAIL exc_epc: got %h expected %h", epc, 32'hBFC0_00FC); end
    rd(5'd8, v); checks++;
    if (v !== 32'h1234_5671) begin errors++; $display("FAIL exc_badvaddr: got %h expected %h", v, 32'h1234_5671); end
    rd(5'd13, v); checks++;
    if (v !== 32'h8000_0010) begin errors++; $display("FAIL exc_cause: got %h expected %h", v, 32'h8000_0010); end
    rd(5'd12, v); checks++;
    if (v !== 32'h0040_0002) begin errors++; $display("FAIL exc_status: got %h expected %h", v, 32'h0040_0002); end
    checks++;
    if (cp0_data.status.exl !== 1'b1) begin errors++; $display("FAIL exc_view_exl: got %b expected %b", cp0_data.status.exl, 1'b1); end
    // nested exception while EXL=1
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h0000_1000;
    exc_in_delay_slot = 1'b0; exc_badvaddr = 32'hFFFF_FFFF;
    step();
    exc_valid = 1'b0;
    checks++;
    if (epc !== 32'hBFC0_00FC) begin errors++; $display("FAIL nested_epc: got %h expected %h", epc, 32'hBFC0_00FC); end
    rd(5'd13, v); checks++;
    if (v !== 32'h8000_0020) begin errors++; $display("FAIL nested_cause: got %h expected %h", v, 32'h8000_0020); end
    rd(5'd8, v); checks++;
    if (v !== 32'h1234_5671) begin errors++; $display("FAIL nested_badvaddr: got %h expected %h", v, 32'h1234_5671); end
    eret = 1'b1;
    step();
    eret = 1'b0;
    rd(5'd12, v); checks++;
    if (v !== 32'h0040_0000) begin errors++; $display("FAIL eret_status: got %h expected %h", v, 32'h0040_0000); end
  endtask

  task automatic test_masks();
    logic [31:0] v;
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd(5'd12, v); checks++;
    if (v !== 32'h0040_FF03) begin errors++; $display("FAIL status_mask: got %h expected %h", v, 32'h0040_FF03); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, v); checks++;
    if (v !== 32'h8000_0320) begin errors++; $display("FAIL cause_mask: got %h expected %h", v, 32'h8000_0320); end
    checks++;
    if (interrupt_info !== 8'h03) begin errors++; $display("FAIL sw_intinfo: got %h expected %h", interrupt_info, 8'h03); end
    mtc0(5'd8, 32'hAAAA_AAAA);
    rd(5'd8, v); checks++;
    if (v !== 32'h1234_5671) begin errors++; $display("FAIL badvaddr_ro: got %h expected %h", v, 32'h1234_5671); end
    mtc0(5'd20, 32'h5555_5555);
    rd(5'd20, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL unmapped_wr: got %h expected %h", v, 32'h0); end
    mtc0(5'd13, 32'h0);
    mtc0(5'd12, 32'h0);
    rd(5'd12, v); checks++;
    if (v !== 32'h0040_0000) begin errors++; $display("FAIL status_clear: got %h expected %h", v, 32'h0040_0000); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] v;
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h0040_0020;
    exc_in_delay_slot = 1'b0; exc_badvaddr = 32'h0000_5555;
    eret = 1'b1; we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
    step();
    exc_valid = 1'b0; eret = 1'b0; we = 1'b0;
    checks++;
    if (epc !== 32'h0040_0020) begin errors++; $display("FAIL same_epc: got %h expected %h", epc, 32'h0040_0020); end
    rd(5'd12, v); checks++;
    if (v !== 32'h0040_0002) begin errors++; $display("FAIL same_status: got %h expected %h", v, 32'h0040_0002); end
    rd(5'd13, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL same_cause: got %h expected %h", v, 32'h0); end
    // ERET beats MTC0
    eret = 1'b1; we = 1'b1; waddr = 5'd12; wdata = 32'hFFFF_FFFF;
    step();
    eret = 1'b0; we = 1'b0;
    rd(5'd12, v); checks++;
    if (v !== 32'h0040_0000) begin errors++; $display("FAIL eret_vs_mtc0: got %h expected %h", v, 32'h0040_0000); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    mtc0(5'd12, 32'h0000_8000);
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 20; i++) step();
    rd(5'd9, v); checks++;
    if (v !== 32'd10) begin errors++; $display("FAIL timer_count: got %h expected %h", v, 32'd10); end
    checks++;
    if (interrupt_info !== 8'h00) begin errors++; $display("FAIL timer_early: got %h expected %h", interrupt_info, 8'h00); end
    step();
    checks++;
    if (interrupt_info !== 8'h80) begin errors++; $display("FAIL timer_fire: got %h expected %h", interrupt_info, 8'h80); end
    rd(5'd13, v); checks++;
    if (v !== 32'h4000_8000) begin errors++; $display("FAIL timer_cause: got %h expected %h", v, 32'h4000_8000); end
    step(); step(); step();
    checks++;
    if (interrupt_info !== 8'h80) begin errors++; $display("FAIL timer_sticky: got %h expected %h", interrupt_info, 8'h80); end
    mtc0(5'd11, 32'd100);
    checks++;
    if (interrupt_info !== 8'h00) begin errors++; $display("FAIL timer_clear: got %h expected %h", interrupt_info, 8'h00); end
    mtc0(5'd9, 32'hFFFF_FFFF);
    step();
    rd(5'd9, v); checks++;
    if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_hold: got %h expected %h", v, 32'hFFFF_FFFF); end
    step();
    rd(5'd9, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL count_wrap: got %h expected %h", v, 32'h0); end
    step();
    mtc0(5'd9, 32'd5);
    step();
    rd(5'd9, v); checks++;
    if (v !== 32'd5) begin errors++; $display("FAIL count_phase: got %h expected %h", v, 32'd5); end
    step();
    rd(5'd9, v); checks++;
    if (v !== 32'd6) begin errors++; $display("FAIL count_inc: got %h expected %h", v, 32'd6); end
  endtask

  task automatic test_ext_int();
    mtc0(5'd12, 32'h0000_0400);
    ext_int = 6'b000001;
    #1;
    checks++;
    if (interrupt_info !== 8'h00) begin errors++; $display("FAIL ext_latency: got %h expected %h", interrupt_info, 8'h00); end
    step();
    checks++;
    if (interrupt_info !== 8'h04) begin errors++; $display("FAIL ext_set: got %h expected %h", interrupt_info, 8'h04); end
    ext_int = 6'b000000;
    #1;
    checks++;
    if (interrupt_info !== 8'h04) begin errors++; $display("FAIL ext_hold: got %h expected %h", interrupt_info, 8'h04); end
    step();
    checks++;
    if (interrupt_info !== 8'h00) begin errors++; $display("FAIL ext_drop: got %h expected %h", interrupt_info, 8'h00); end
  endtask

  task automatic test_reset_override();
    logic [31:0] v;
    reset = 1'b1; exc_valid = 1'b1; exc_code = 5'd5; exc_pc = 32'h1111_1110;
    exc_badvaddr = 32'h2222_2222; we = 1'b1; waddr = 5'd12; wdata = 32'hFFFF_FFFF;
    step();
    reset = 1'b0; exc_valid = 1'b0; we = 1'b0;
    rd(5'd12, v); checks++;
    if (v !== 32'h0040_0000) begin errors++; $display("FAIL rst_ovr_status: got %h expected %h", v, 32'h0040_0000); end
    rd(5'd8, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rst_ovr_badvaddr: got %h expected %h", v, 32'h0); end
    checks++;
    if (epc !== 32'h0) begin errors++; $display("FAIL rst_ovr_epc: got %h expected %h", epc, 32'h0); end
  endtask

  initial begin
    reset = 1'b1; ext_int = '0; exc_valid = 1'b0; exc_code = '0; exc_pc = '0;
    exc_in_delay_slot = 1'b0; exc_badvaddr = '0; eret = 1'b0; we = 1'b0;
    waddr = '0; wdata = '0; raddr = '0;
    test_reset();
    test_exception();
    test_masks();
    test_same_cycle();
    test_timer();
    test_ext_int();
    test_reset_override();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 state holder and the consuming end of the exception handshake.
- Accepts one committed exception record per cycle from the exception detector, then updates EPC, Cause, Status and BadVAddr.
- Runs the Count/Compare timer and combines hardware/software/timer interrupt requests.
- Drives the masked pending-interrupt vector and CP0 state back to the detector; serves MFC0/MTC0/ERET from the memory stage.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV clock cycles.
- RESET_STATUS, 32'h0040_0000, Status value at reset (BEV=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ext_int  in  6  hardware interrupt lines, level-sensitive, sampled each cycle
- exc_valid  in  1  committed exception this cycle
- exc_code  in  5  ExcCode of the exception
- exc_pc  in  32  PC of the faulting instruction
- exc_in_delay_slot  in  1  faulting instruction is in a branch delay slot
- exc_badvaddr  in  32  faulting address for AdEL/AdES
- eret  in  1  ERET committed this cycle
- we  in  1  MTC0 write enable
- waddr  in  5  MTC0 register number
- wdata  in  32  MTC0 data
- raddr  in  5  MFC0 register number
- rdata  out  32  MFC0 data, combinational
- epc  out  32  current EPC register, used as the ERET target
- cp0_data  out  cp0_regs_t  packed Status/Cause/EPC/BadVAddr/Count/Compare view
- interrupt_info  out  8  Cause.IP & Status.IM

Behaviour:
- Reset (clk edge with reset=1):
  - Status=RESET_STATUS; Cause, EPC, BadVAddr, Count and Compare are 0.
  - Timer pending flag TI=0; divider phase=0.
  - Consequently interrupt_info=0 and epc=0.
  - Reset in the middle of any operation overrides everything else.
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Any other number reads 0 and ignores writes.
- Writable masks:
  - Status: IM[15:8], EXL[1], IE[0]; all other bits hold their reset value.
  - Cause: IP[9:8] only.
  - EPC, Count, Compare: all 32 bits.
  - BadVAddr: read-only to software.
- Cause composition each cycle:
  - IP[7] = ext_int[5] | TI.
  - IP[6:2] = ext_int[4:0], registered, so there is 1-cycle latency to interrupt_info.
  - Cause.TI (bit 30) mirrors TI.
- Timer:
  - Divider counts 0..COUNT_DIV-1; Count++ when it wraps.
  - Count wraps 32'hFFFF_FFFF -> 0.
  - TI is set in the cycle after Count becomes equal to Compare, and stays set.
  - TI is cleared only by an MTC0 to Compare.
  - An MTC0 to Count beats a same-cycle increment and resets divider phase to 0.
- Exception commit (exc_valid=1), applied at the next clk edge:
  - If Status.EXL=0: EPC = exc_in_delay_slot ? exc_pc-4 : exc_pc, and Cause.BD = exc_in_delay_slot.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Always: Status.EXL=1 and Cause.ExcCode=exc_code.
  - BadVAddr=exc_badvaddr only when exc_code is AdEL (4) or AdES (5).
- ERET (eret=1 and exc_valid=0): Status.EXL=0.
- Same-cycle priority: reset > exc_valid > eret > MTC0. A dropped MTC0 has no side effects, including no clear of TI.
- MFC0: rdata reflects register state before any same-cycle write; there is no write-to-read bypass, because pipeline ordering is handled by hazard logic.
- epc and cp0_data are register outputs and carry no combinational path from the inputs.

Decomposition:
- Shared package mips.svh holds:
  - CP0 register-number constants;
  - CODE_* exception codes (CODE_INT, CODE_ADEL, CODE_ADES, ...);
  - packed typedefs cp0_status_t, cp0_cause_t, cp0_regs_t;
  - writable-mask constants.
- One natural sub-module: cp0_timer. It holds the divider, Count, Compare and TI, with ports for count/compare write and a timer_int output.

Test Plan:
- Reset, then read regs 12, 13, 14 -> rdata = 32'h0040_0000, 0, 0; interrupt_info = 0.
- exc_valid with code=4, pc=32'hBFC0_0100, in_delay_slot=1, badvaddr=32'h1234_5671 -> EPC = 32'hBFC0_00FC, Cause.BD=1, ExcCode=4, BadVAddr=32'h1234_5671, Status.EXL=1.
  - A second exception code=8 while EXL=1 -> EPC unchanged, ExcCode=8.
  - Then eret -> EXL=0.
- MTC0 Compare=10, Count=0 -> TI=1 on the cycle after Count reaches 10 (about 20 clocks later).
  - With Status.IM[7]=1, interrupt_info[7]=1.
  - MTC0 Compare=100 -> TI=0 next cycle.
- MTC0 Status=32'hFFFF_FFFF -> reads 32'h0040_FF03.
  - MTC0 Cause=32'hFFFF_FFFF -> only IP[1:0] set.
  - Write to reg 8 -> no change.
- Same-cycle exc_valid + MTC0 EPC=32'hDEAD_BEEF + eret -> exception update applied; EPC = exception-derived value; EXL=1.
- ext_int=6'b000001, IM[2]=1 -> interrupt_info[2]=1 one cycle later; clears one cycle after ext_int drops.
